coax_buffered_tx: RTL
=====================

# coax_buffered_tx

Buffered 3270 coax transmitter: the send-side counterpart of `coax_buffered_rx`. Accepts 10-bit words from `control` into a FIFO, then serialises them as one frame onto the coax line. The frame is line quiesce, then code violation, then per word a sync bit, 10 data bits and a parity bit, then an end sequence. All symbols are Manchester-coded at `CLOCKS_PER_BIT` system clocks per bit. Sits in `top` between `control` and the line driver / RX loopback mux.

## Interface
- `CLOCKS_PER_BIT`, 16, system clocks per bit time; must be even and ≥ 8.
- `DEPTH`, 256, FIFO depth in words; power of two.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears FIFO, FSM, counters and error.
- `data` in 10: word to enqueue.
- `load_strobe` in 1: one-cycle pulse; enqueues `data` unless full.
- `full` out 1: FIFO full.
- `empty` out 1: FIFO empty.
- `error` out 1: sticky; set on a `load_strobe` while `full`.
- `active` out 1: frame in progress, from the first quiesce half-bit to the last end-sequence cycle.
- `tx` out 1: serial line output.
- `tx_delay` out 1: `tx` delayed by `CLOCKS_PER_BIT/4` clocks, used for pre-emphasis.
- `tx_inverted` out 1: `~tx` while `active`, otherwise 0.

## Operation
- Manchester: bit b drives `~b` for the first half-bit and `b` for the second half-bit; the mid-bit transition carries the value.
- FSM states: IDLE → QUIESCE → CODE_VIOLATION → SYNC → DATA → PARITY → (SYNC | END) → IDLE.
- IDLE: `tx` = 0, `active` = 0. Leave IDLE when `empty` = 0.
- QUIESCE: 5 bits of value 1.
- CODE_VIOLATION: `tx` high for 1.5 bit times, then low for 1.5 bit times.
- SYNC: 1 bit of value 1.
- DATA: FIFO word popped at SYNC entry; 10 bits sent MSB first.
- PARITY: one bit chosen so data plus parity has an even count of ones.
- After PARITY: if the FIFO is non-empty, go to SYNC with the next word (same frame); otherwise go to END.
- END: `tx` high for 1 bit time, low for 1.5 bit times, then IDLE.
- A word enqueued during END is not appended to the current frame; it starts a new frame after IDLE.
- Full FIFO with `load_strobe`: word dropped, FIFO unchanged, `error` ← 1.
- Simultaneous push and pop while full: the pop is honoured and the push is accepted.
- `error` clears only on `reset`.
- `reset` mid-frame: outputs go to reset values immediately. No end sequence is sent and queued words are discarded.

## Timing
- Reset values: `tx` = 0, `tx_delay` = 0, `tx_inverted` = 0, `active` = 0, `full` = 0, `empty` = 1, `error` = 0.
- A `load_strobe` sampled at edge N into an empty, idle block causes `empty` = 0 after edge N+1. QUIESCE starts at edge N+2, with `active` = 1 and `tx` = 0 for the first half-bit.
- Bit counter counts 0 … `CLOCKS_PER_BIT`−1; the half-bit boundary is at `CLOCKS_PER_BIT/2`.
- Single-word frame at 16 clocks per bit: 80 (quiesce) + 48 (code violation) + 192 (12 bits) + 40 (end) = 360 clocks of `active`.
- Each extra word adds 192 clocks.
- FIFO pop occurs on the first cycle of SYNC. `full` deasserts the following cycle.
- `tx` is registered and glitch-free.

## Configuration
- `COAX_TX_DELAY_EN` defined: `tx_delay` is generated by a `CLOCKS_PER_BIT/4`-stage shift register.
- `COAX_TX_DELAY_EN` undefined: `tx_delay` is tied to 0 and the shift register is not instantiated.

## Structure
- Shared package `coax_pkg`:
  - FSM state encoding.
  - Constants `QUIESCE_BITS` = 5, `WORD_BITS` = 10, `CV_HALF_BITS` = 3, `END_HIGH_BITS` = 1, `END_LOW_HALF_BITS` = 3.
  - Parity function.
- One sub-module, `coax_tx_fifo`: synchronous FIFO, `DEPTH` × 10, async reset, with full/empty flags and a registered read.

## Test plan
- Single word 10'h2AB, 16 clocks per bit:
  - `active` is high for exactly 360 clocks.
  - Decoded bits are 11111, then the code violation, then 1, then 1010101011, then parity 0, then the end sequence.
- Three back-to-back words 10'h000, 10'h3FF, 10'h155:
  - One frame with 3 sync bits and parity bits 0, 0, 1.
  - `active` lasts 360 + 2×192 clocks.
- 257 strobes with `DEPTH` = 256 while the line is idle and blocked:
  - `full` = 1 after the 256th strobe.
  - 257th strobe sets `error` = 1; 256 words are sent.
- `reset` asserted mid-DATA:
  - Same cycle: `tx` = 0, `active` = 0, `empty` = 1, `error` = 0.
  - No further transitions.
- Loopback through `coax_buffered_rx`: random 64 words → identical words read back with `rx_error` = 0.
- `COAX_TX_DELAY_EN` defined:
  - `tx_delay` equals `tx` shifted by 4 clocks.
  - With the macro undefined, `tx_delay` stays at constant 0.

Source files
------------

// File: rtl/coax_pkg.sv
// coax_pkg: shared definitions for the buffered 3270 coax transmitter.
//   tx_state_t   - transmitter FSM states
//   *_BITS       - frame geometry constants (bits or half-bits)
//   parity()     - even-parity bit for one data word
package coax_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_CODE_VIOLATION,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_END
  } tx_state_t;

  localparam int unsigned QUIESCE_BITS      = 5;
  localparam int unsigned WORD_BITS         = 10;
  localparam int unsigned CV_HALF_BITS      = 3;
  localparam int unsigned END_HIGH_BITS     = 1;
  localparam int unsigned END_LOW_HALF_BITS = 3;

  // Bit that makes data plus parity carry an even number of ones.
  function automatic logic parity(input logic [WORD_BITS-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/coax_tx_fifo.sv
// coax_tx_fifo: synchronous DEPTH x 10 word FIFO with registered read.
//   clk, reset       - clock, asynchronous active-high reset
//   wr_en, wr_data   - push request and word (ignored when full unless popping)
//   rd_en, rd_data   - pop request; rd_data updates on the popping edge
//   full             - DEPTH words stored
//   empty            - no words stored, lagging the occupancy by one clock
module coax_tx_fifo
  import coax_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 empty_q;
  logic                 do_wr;
  logic                 do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = empty_q;
  assign do_rd = rd_en && (count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Registered flag: a first push shows as non-empty one clock later.
      empty_q <= (count == '0);
    end
  end

endmodule

// File: rtl/coax_buffered_tx.sv
// coax_buffered_tx: buffered 3270 coax transmitter. Words loaded from control
// are queued, then sent as one Manchester-coded frame: quiesce, code
// violation, per word {sync, 10 data bits MSB first, even parity}, end sequence.
//   clk, reset   - clock, asynchronous active-high reset
//   data         - word to enqueue on load_strobe
//   load_strobe  - one-cycle enqueue pulse
//   full, empty  - FIFO status
//   error        - sticky: load_strobe seen while full (word dropped)
//   active       - frame in progress
//   tx           - registered serial line output
//   tx_delay     - tx delayed CLOCKS_PER_BIT/4 clocks (0 unless COAX_TX_DELAY_EN)
//   tx_inverted  - ~tx while active, else 0
// Build option: define COAX_TX_DELAY_EN to generate tx_delay.
module coax_buffered_tx
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 16,
  parameter int unsigned DEPTH          = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 load_strobe,
  output logic                 full,
  output logic                 empty,
  output logic                 error,
  output logic                 active,
  output logic                 tx,
  output logic                 tx_delay,
  output logic                 tx_inverted
);

  localparam int unsigned HALF  = CLOCKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     bit_cnt, cnt_n;
  logic [3:0]           bit_idx, idx_n;
  logic [4:0]           hpos, hpos_n;
  logic                 last_bit, half_last, second_n;
  logic                 tx_q, tx_d, error_q, pop;
  logic [WORD_BITS-1:0] word;

  coax_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_strobe),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (word),
    .full    (full),
    .empty   (empty)
  );

  assign last_bit  = (bit_cnt == CNT_W'(CLOCKS_PER_BIT - 1));
  assign half_last = last_bit || (bit_cnt == CNT_W'(HALF - 1));
  // Position within the state counted in half-bits.
  assign hpos      = {bit_idx, (bit_cnt >= CNT_W'(HALF))};
  assign pop       = (state == ST_SYNC) && (bit_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      tx_q    <= tx_d;
      error_q <= error_q | (load_strobe & full & ~pop);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = last_bit ? '0 : bit_cnt + 1'b1;
    idx_n   = last_bit ? bit_idx + 1'b1 : bit_idx;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!empty) state_n = ST_QUIESCE;
      end
      ST_QUIESCE:
        if (last_bit && bit_idx == 4'(QUIESCE_BITS - 1)) begin
          state_n = ST_CODE_VIOLATION;
          idx_n   = '0;
        end
      ST_CODE_VIOLATION:
        if (half_last && hpos == 5'(2*CV_HALF_BITS - 1)) begin
          state_n = ST_SYNC;
          cnt_n   = '0;
          idx_n   = '0;
        end
      ST_SYNC:
        if (last_bit) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      ST_DATA:
        if (last_bit && bit_idx == 4'(WORD_BITS - 1)) begin
          state_n = ST_PARITY;
          idx_n   = '0;
        end
      ST_PARITY:
        if (last_bit) begin
          state_n = empty ? ST_END : ST_SYNC;
          idx_n   = '0;
        end
      ST_END:
        if (half_last && hpos == 5'(2*END_HIGH_BITS + END_LOW_HALF_BITS - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line level is derived from the upcoming state/counters so that the
  // registered tx lines up with active.
  always_comb begin
    second_n = (cnt_n >= CNT_W'(HALF));
    hpos_n   = {idx_n, second_n};
    tx_d     = 1'b0;
    case (state_n)
      ST_QUIESCE:        tx_d = second_n;
      ST_CODE_VIOLATION: tx_d = (hpos_n < 5'(CV_HALF_BITS));
      ST_SYNC:           tx_d = second_n;
      ST_DATA:           tx_d = second_n ? word[4'(WORD_BITS - 1) - idx_n]
                                         : ~word[4'(WORD_BITS - 1) - idx_n];
      ST_PARITY:         tx_d = second_n ? parity(word) : ~parity(word);
      ST_END:            tx_d = (hpos_n < 5'(2*END_HIGH_BITS));
      default:           tx_d = 1'b0;
    endcase
  end

  assign active      = (state != ST_IDLE);
  assign tx          = tx_q;
  assign tx_inverted = active & ~tx_q;
  assign error       = error_q;

`ifdef COAX_TX_DELAY_EN
  localparam int unsigned DLY = CLOCKS_PER_BIT / 4;
  logic [DLY-1:0] dly_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dly_sr <= '0;
    else       dly_sr <= {dly_sr[DLY-2:0], tx_q};
  end

  assign tx_delay = dly_sr[DLY-1];
`else
  assign tx_delay = 1'b0;
`endif

endmodule
